mem_stage_pipe: RTL and testbench

//  Y86-64 pipeline memory stage, next generation: word-indexed data RAM plus the M->W pipeline register.

---
 rtl/mem_stage_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: Y86-64 memory stage with word-indexed data RAM and the M->W register.
// Reads may take RD_LAT (0..7) extra cycles; m_stall asks the hazard unit to hold F/D/E/M.
// Stores are suppressed on any address fault or when a non-AOK status is already in W.
// Optional build macro MEM_ALIGN_CHK_EN: flag misaligned (addr[2:0] != 0) accesses as ADR
// and index words by addr >> 3. Without it, the address is the word index directly.
// DEPTH must be at least 2; RD_LAT must fit in the 3-bit wait counter.
module mem_stage_pipe #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       M_stat,
    input  logic [3:0]       M_icode,
    input  logic [WIDTH-1:0] M_valE,
    input  logic [WIDTH-1:0] M_valA,
    input  logic [3:0]       M_destE,
    input  logic [3:0]       M_destM,
    input  logic             W_stall,
    input  logic             W_bubble,
    output logic [3:0]       m_stat,
    output logic [WIDTH-1:0] m_valM,
    output logic             m_stall,
    output logic [3:0]       W_stat,
    output logic [3:0]       W_icode,
    output logic [WIDTH-1:0] W_valE,
    output logic [WIDTH-1:0] W_valM,
    output logic [3:0]       W_destE,
    output logic [3:0]       W_destM
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef MEM_ALIGN_CHK_EN
    localparam int unsigned ShAmt = 3;
`else
    localparam int unsigned ShAmt = 0;
`endif

    localparam logic [WIDTH-1:0] DepthW = WIDTH'(DEPTH);
    localparam logic [2:0]       RdLat  = 3'(RD_LAT);

    localparam logic [3:0] StatAok = 4'b1000;
    localparam logic [3:0] StatAdr = 4'b0010;

    localparam logic [3:0] IcNop    = 4'h1;
    localparam logic [3:0] IcRmmovq = 4'h4;
    localparam logic [3:0] IcMrmovq = 4'h5;
    localparam logic [3:0] IcCall   = 4'h8;
    localparam logic [3:0] IcRet    = 4'h9;
    localparam logic [3:0] IcPushq  = 4'hA;
    localparam logic [3:0] IcPopq   = 4'hB;
    localparam logic [3:0] RegNone  = 4'hF;

    typedef enum logic {StIdle, StWait} state_e;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             is_rd, is_wr;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] word_full;
    logic             misalign;
    logic             addr_err;
    logic [AW-1:0]    word_idx;
    logic             rd_ok, wr_en;
    logic             stall_raw;

    logic [3:0]       w_stat_q, w_stat_d;
    logic [3:0]       w_icode_q, w_icode_d;
    logic [WIDTH-1:0] w_vale_q, w_vale_d;
    logic [WIDTH-1:0] w_valm_q, w_valm_d;
    logic [3:0]       w_deste_q, w_deste_d;
    logic [3:0]       w_destm_q, w_destm_d;

    // Decode the access type, pick the address and check it against the RAM range.
    always_comb begin
        is_rd = (M_icode == IcMrmovq) || (M_icode == IcRet) || (M_icode == IcPopq);
        is_wr = (M_icode == IcRmmovq) || (M_icode == IcCall) || (M_icode == IcPushq);
        // popq/ret fetch from the stack pointer carried in valA; everything else uses valE.
        mem_addr  = (is_rd && (M_icode != IcMrmovq)) ? M_valA : M_valE;
        word_full = mem_addr >> ShAmt;
`ifdef MEM_ALIGN_CHK_EN
        misalign  = (mem_addr[2:0] != 3'b000);
`else
        misalign  = 1'b0;
`endif
        addr_err  = (is_rd || is_wr) && ((word_full >= DepthW) || misalign);
        word_idx  = word_full[AW-1:0];
        rd_ok     = is_rd && !addr_err;
        m_stat    = addr_err ? StatAdr : M_stat;
    end

    // Wait-state FSM: next state, counter and the raw stall request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd_ok && (RdLat != 3'd0)) begin
                    stall_raw = 1'b1;
                    state_d   = StWait;
                    // The entry cycle already counts unless W is frozen.
                    cnt_d     = W_stall ? 3'd0 : 3'd1;
                end
            end
            StWait: begin
                if (!rd_ok) begin
                    // M no longer holds a read (upstream flush); abandon the wait.
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else if (cnt_q < RdLat) begin
                    stall_raw = 1'b1;
                    if (!W_stall) begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (!W_stall) begin
                    // Data is handed to W this cycle; stay put until W actually takes it.
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end
            end
        endcase
    end

    // Stall output is forced low while reset is asserted, independent of the clock.
    always_comb begin
        m_stall = rst_n && stall_raw;
        m_valM  = (rd_ok && !m_stall) ? mem_q[word_idx] : '0;
    end

    // Wait-state FSM register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A store commits only when it and everything ahead of it in W is clean.
    always_comb begin
        wr_en = is_wr && !addr_err && (M_stat == StatAok) && (m_stat == StatAok) &&
                (w_stat_q == StatAok) && !W_stall && rst_n;
    end

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word_idx] <= M_valA;
        end
    end

    // W register next state: hold > stall bubble > explicit bubble > load.
    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_deste_d = w_deste_q;
        w_destm_d = w_destm_q;
        if (W_stall) begin
            // hold
        end else if (m_stall || W_bubble) begin
            w_stat_d  = StatAok;
            w_icode_d = IcNop;
            w_vale_d  = '0;
            w_valm_d  = '0;
            w_deste_d = RegNone;
            w_destm_d = RegNone;
        end else begin
            w_stat_d  = m_stat;
            w_icode_d = M_icode;
            w_vale_d  = M_valE;
            w_valm_d  = m_valM;
            w_deste_d = M_destE;
            w_destm_d = M_destM;
        end
    end

    // W register; reset loads a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_stat_q  <= StatAok;
            w_icode_q <= IcNop;
            w_vale_q  <= '0;
            w_valm_q  <= '0;
            w_deste_q <= RegNone;
            w_destm_q <= RegNone;
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
            w_deste_q <= w_deste_d;
            w_destm_q <= w_destm_d;
        end
    end

    assign W_stat  = w_stat_q;
    assign W_icode = w_icode_q;
    assign W_valE  = w_vale_q;
    assign W_valM  = w_valm_q;
    assign W_destE = w_deste_q;
    assign W_destM = w_destm_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe (RD_LAT=3): the driver pushes the expected W contents of
// each accepted instruction, a negedge monitor pops and compares whenever W loads.
module tb_mem_stage_pipe;

    localparam int W      = 64;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 3;
`ifdef MEM_ALIGN_CHK_EN
    localparam int SH = 3;
`else
    localparam int SH = 0;
`endif

    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] HLT = 4'b0100;
    localparam logic [3:0] ADR = 4'b0010;
    localparam logic [3:0] INS = 4'b0001;

    logic         clk, rst_n;
    logic [3:0]   M_stat, M_icode, M_destE, M_destM;
    logic [W-1:0] M_valE, M_valA;
    logic         W_stall, W_bubble;
    logic [3:0]   m_stat;
    logic [W-1:0] m_valM;
    logic         m_stall;
    logic [3:0]   W_stat, W_icode, W_destE, W_destM;
    logic [W-1:0] W_valE, W_valM;

    mem_stage_pipe #(.WIDTH(W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .M_valA(M_valA),
        .M_destE(M_destE), .M_destM(M_destM), .W_stall(W_stall), .W_bubble(W_bubble),
        .m_stat(m_stat), .m_valM(m_valM), .m_stall(m_stall),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_destE(W_destE), .W_destM(W_destM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   stat;
        logic [3:0]   icode;
        logic [W-1:0] vale;
        logic [W-1:0] valm;
        logic [3:0]   deste;
        logic [3:0]   destm;
    } wexp_t;

    wexp_t        exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mem_m [DEPTH];
    logic [3:0]   w_stat_m;
    bit           mon_en = 1'b0;
    bit           pend_load = 1'b0;
    bit           pend_bub = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare W one half-cycle after each edge at which it should have changed.
    always @(negedge clk) begin
        wexp_t e;
        if (pend_load) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w_load_unexpected: got W_icode %h, required no load", W_icode);
            end else begin
                e = exp_q.pop_front();
                check("W_stat", 64'(W_stat), 64'(e.stat));
                check("W_icode", 64'(W_icode), 64'(e.icode));
                check("W_valE", W_valE, e.vale);
                check("W_valM", W_valM, e.valm);
                check("W_destE", 64'(W_destE), 64'(e.deste));
                check("W_destM", 64'(W_destM), 64'(e.destm));
            end
        end else if (pend_bub) begin
            check("bub_icode", 64'(W_icode), 64'h1);
            check("bub_stat", 64'(W_stat), 64'(AOK));
            check("bub_dest", 64'({W_destE, W_destM}), 64'hFF);
            check("bub_vals", W_valE | W_valM, 64'h0);
        end
        pend_load = mon_en && rst_n && !W_stall && !m_stall && !W_bubble;
        pend_bub  = mon_en && rst_n && !W_stall && (m_stall || W_bubble);
    end

    // Drive one instruction until W accepts it; the reference model decides the outcome.
    task automatic issue(input logic [3:0] stat, input logic [3:0] icode, input logic [W-1:0] vale,
                         input logic [W-1:0] vala, input logic [3:0] de, input logic [3:0] dm,
                         input int stall_pct);
        bit           is_rd, is_wr, err, accepted;
        logic [W-1:0] addr, idx, valm;
        logic [3:0]   exp_stat;
        int           exp_lat, stalls;
        wexp_t        e;
        is_rd = icode inside {4'h5, 4'h9, 4'hB};
        is_wr = icode inside {4'h4, 4'h8, 4'hA};
        addr  = (icode == 4'h9 || icode == 4'hB) ? vala : vale;
        idx   = addr >> SH;
        err   = (is_rd || is_wr) && (idx >= DEPTH);
`ifdef MEM_ALIGN_CHK_EN
        if ((is_rd || is_wr) && (addr % 8 != 0)) err = 1'b1;
`endif
        exp_stat = err ? ADR : stat;
        exp_lat  = (is_rd && !err) ? RD_LAT : 0;
        M_stat = stat; M_icode = icode; M_valE = vale; M_valA = vala;
        M_destE = de; M_destM = dm; W_bubble = 1'b0;
        stalls = 0;
        accepted = 1'b0;
        for (int cyc = 0; cyc < 64 && !accepted; cyc++) begin
            W_stall = ($urandom_range(99) < stall_pct);
            @(negedge clk);
            if (cyc == 0) check("m_stat", 64'(m_stat), 64'(exp_stat));
            if (!W_stall && m_stall) begin
                stalls++;
                w_stat_m = AOK;
            end
            if (!W_stall && !m_stall) begin
                accepted = 1'b1;
                valm = (is_rd && !err) ? mem_m[idx[7:0]] : '0;
                check("m_valM", m_valM, valm);
                if (is_wr && !err && stat == AOK && w_stat_m == AOK) mem_m[idx[7:0]] = vala;
                w_stat_m = exp_stat;
                e.stat = exp_stat; e.icode = icode; e.vale = vale; e.valm = valm;
                e.deste = de; e.destm = dm;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no acceptance in 64 cycles, required one");
        end
        check("stall_cycles", 64'(stalls), 64'(exp_lat));
        W_stall = 1'b0;
    endtask

    task automatic idle(input int n);
        M_stat = AOK; M_icode = 4'h1; M_valE = '0; M_valA = '0;
        M_destE = 4'hF; M_destM = 4'hF; W_stall = 1'b0; W_bubble = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        w_stat_m = AOK;
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [3:0]   ic, st;
        logic [W-1:0] a, ve, va;
        logic [3:0]   icodes [9];
        icodes = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b0;
        w_stat_m = AOK;
        #2;
        check("rst_W_icode", 64'(W_icode), 64'h1);
        check("rst_W_stat", 64'(W_stat), 64'(AOK));
        check("rst_W_dest", 64'({W_destE, W_destM}), 64'hFF);
        check("rst_W_vals", W_valE | W_valM, 64'h0);
        check("rst_m_stall", 64'(m_stall), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Fill words 0..15 so every later in-range read has a known value.
        for (int w = 0; w < 16; w++) issue(AOK, 4'h4, 64'(w) << SH, rnd64(), 4'hF, 4'hF, 0);

        // Store then read back immediately.
        issue(AOK, 4'h4, 64'(10) << SH, 64'hDEAD, 4'hF, 4'hF, 0);
        issue(AOK, 4'h5, 64'(10) << SH, 64'h0, 4'hF, 4'h3, 0);

        // Out-of-range push flags ADR; the store behind it is then suppressed.
        issue(AOK, 4'hA, 64'(300) << SH, 64'h1234, 4'h4, 4'hF, 0);
        issue(AOK, 4'h4, 64'(5) << SH, 64'h7, 4'hF, 4'hF, 0);
        issue(AOK, 4'h5, 64'(5) << SH, 64'h0, 4'hF, 4'h1, 0);

        // Store under heavy W_stall lands exactly once.
        issue(AOK, 4'h4, 64'(6) << SH, 64'h9, 4'hF, 4'hF, 80);
        issue(AOK, 4'h5, 64'(6) << SH, 64'h0, 4'hF, 4'h2, 0);
        issue(AOK, 4'hB, 64'h0, 64'(7) << SH, 4'h4, 4'h6, 50);

`ifdef MEM_ALIGN_CHK_EN
        issue(AOK, 4'h5, 64'h13, 64'h0, 4'hF, 4'h1, 0);
        issue(AOK, 4'h5, 64'h10, 64'h0, 4'hF, 4'h1, 0);
`endif

        // Reset in the middle of a wait with W frozen on a real instruction.
        issue(AOK, 4'h2, 64'h55, 64'h0, 4'h3, 4'hF, 0);
        mon_en = 1'b0;
        M_icode = 4'h5; M_valE = 64'(3) << SH; M_destE = 4'hF; M_destM = 4'h2;
        W_stall = 1'b1;
        @(negedge clk);
        check("wait_enter_stall", 64'(m_stall), 64'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wait_hold_stall", 64'(m_stall), 64'h1);
        check("wait_W_held", 64'(W_icode), 64'h2);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_W_icode", 64'(W_icode), 64'h1);
        check("midrst_W_destE", 64'(W_destE), 64'hF);
        check("midrst_m_stall", 64'(m_stall), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        W_stall = 1'b0;
        w_stat_m = AOK;
        mon_en = 1'b1;
        issue(AOK, 4'h5, 64'(3) << SH, 64'h0, 4'hF, 4'h2, 0);

        // Randomized mix.
        for (int n = 0; n < 150; n++) begin
            ic = icodes[$urandom_range(8)];
            a  = 64'($urandom_range(15)) << SH;
            if ($urandom_range(99) < 8) a = 64'(DEPTH + $urandom_range(1000)) << SH;
`ifdef MEM_ALIGN_CHK_EN
            if ($urandom_range(99) < 5) a = a | 64'($urandom_range(7, 1));
`endif
            ve = (ic inside {4'h4, 4'h5, 4'h8, 4'hA}) ? a : rnd64();
            va = (ic inside {4'h9, 4'hB}) ? a : rnd64();
            st = AOK;
            if (!(ic inside {4'h5, 4'h9, 4'hB}) && $urandom_range(99) < 10)
                st = ($urandom_range(1) == 1) ? HLT : INS;
            issue(st, ic, ve, va, 4'($urandom), 4'($urandom), 25);
            if ($urandom_range(99) < 20) idle($urandom_range(2, 1));
        end

        idle(3);
        check("scoreboard_drain", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
